// File: rtl/pi_sched_pkg.sv
// Shared types and constants for the PI scheduler: FSM states, per-channel
// configuration record, data widths and the optional WAIT timeout length.
package pi_sched_pkg;

  localparam int GAIN_W     = 16;
  localparam int DUTY_W     = 8;
  localparam int DATA_W     = 32;
  localparam int PI_TIMEOUT = 256;
  localparam int TO_W       = $clog2(PI_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT
  } pi_state_t;

  typedef struct packed {
    logic signed [GAIN_W-1:0] kp;
    logic signed [GAIN_W-1:0] ki;
    logic signed [DATA_W-1:0] sp;
  } chan_cfg_t;

endpackage

// File: rtl/pi_scheduler_if.sv
// Handshake between the scheduler (master) and the shared PI engine (slave):
// start pulse plus operands out, done/duty/error back.
interface pi_scheduler_if;
  import pi_sched_pkg::*;

  logic              o_pi_start;
  logic [DATA_W-1:0] o_pi_gain;
  logic [DATA_W-1:0] o_pi_sp;
  logic [DATA_W-1:0] o_pi_rpm;
  logic              i_pi_done;
  logic [DUTY_W-1:0] i_pi_dout;
  logic              i_pi_error;

  modport master (
    output o_pi_start, o_pi_gain, o_pi_sp, o_pi_rpm,
    input  i_pi_done, i_pi_dout, i_pi_error
  );

  modport slave (
    input  o_pi_start, o_pi_gain, o_pi_sp, o_pi_rpm,
    output i_pi_done, i_pi_dout, i_pi_error
  );

endinterface

// File: rtl/pi_scheduler_tick_gen.sv
// Control-period tick generator: free-running counter 0..C_M-1 with
// C_M = DELTA_T[ms] / T_CLK[ns]; o_tick is high in the terminal-count cycle.
module pi_tick_gen #(
  parameter int DELTA_T = 10,
  parameter int T_CLK   = 10
) (
  input  logic i_clk,
  input  logic i_rstn,
  output logic o_tick
);

  localparam longint unsigned CM = (64'(DELTA_T) * 64'd1_000_000) / 64'(T_CLK);
  localparam int CNT_W = (CM > 1) ? $clog2(CM) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign o_tick = (cnt_q == CNT_W'(CM - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt_q <= '0;
    end else if (o_tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/pi_scheduler.sv
// Time-multiplexes one PI engine across NUM_CH motor channels, one round per tick.
// Optional feature: define PI_SCHED_TIMEOUT_EN to fault a channel whose engine stalls in WAIT.
module pi_scheduler
  import pi_sched_pkg::*;
#(
  parameter int  NUM_CH  = 4,
  parameter int  DELTA_T = 10,
  parameter int  T_CLK   = 10,
  localparam int CHW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_en,
  input  logic                     i_cfg_we,
  input  logic [CHW-1:0]           i_cfg_ch,
  input  logic [DATA_W-1:0]        i_cfg_gain,
  input  logic [DATA_W-1:0]        i_cfg_sp,
  input  logic [NUM_CH*DATA_W-1:0] i_rpm,
  pi_scheduler_if.master           pi,
  output logic [NUM_CH*DUTY_W-1:0] o_duty,
  output logic [NUM_CH-1:0]        o_duty_valid,
  output logic [NUM_CH-1:0]        o_fault,
  output logic                     o_busy,
  output logic                     o_overrun
);

  pi_state_t state_q, state_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic [CHW-1:0] nxt_ch;
  logic [CHW-1:0] first_ch;
  logic           first_ok;
  logic           last_ch;
  logic           tick;
  logic           start_round;
  logic           cfg_hit;
  logic           finish_ch;
  logic           timeout;

  chan_cfg_t shadow_q   [NUM_CH];
  chan_cfg_t shadow_nxt [NUM_CH];
  chan_cfg_t active_q   [NUM_CH];

  logic [DATA_W-1:0]        rpm_q;
  logic [NUM_CH*DUTY_W-1:0] duty_q;
  logic [NUM_CH-1:0]        valid_q;
  logic [NUM_CH-1:0]        fault_q;
  logic                     overrun_q;

  pi_tick_gen #(
    .DELTA_T (DELTA_T),
    .T_CLK   (T_CLK)
  ) u_tick (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .o_tick (tick)
  );

  assign cfg_hit     = i_cfg_we && (int'(i_cfg_ch) < NUM_CH);
  assign start_round = (state_q == ST_IDLE) && tick && i_en;
  assign finish_ch   = (state_q == ST_WAIT) && (pi.i_pi_done || timeout);
  assign nxt_ch      = ch_q + 1'b1;
  assign last_ch     = (ch_q == CHW'(NUM_CH - 1));

`ifdef PI_SCHED_TIMEOUT_EN
  logic [TO_W-1:0] wait_cnt_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wait_cnt_q <= '0;
    end else if (state_q != ST_WAIT) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  // A done arriving in the expiry cycle takes precedence over the timeout.
  assign timeout = (state_q == ST_WAIT) && (wait_cnt_q == TO_W'(PI_TIMEOUT - 1)) && !pi.i_pi_done;
`else
  assign timeout = 1'b0;
`endif

  // Shadow bank with this cycle's write folded in, so a round snapshot sees it.
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      shadow_nxt[n] = shadow_q[n];
      if (cfg_hit && (i_cfg_ch == CHW'(n))) begin
        shadow_nxt[n].kp = i_cfg_gain[31:16];
        shadow_nxt[n].ki = i_cfg_gain[15:0];
        shadow_nxt[n].sp = i_cfg_sp;
      end
    end
  end

  always_comb begin
    first_ok = 1'b0;
    first_ch = '0;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (!fault_q[n]) begin
        first_ok = 1'b1;
        first_ch = CHW'(n);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Faulted channels are skipped one per cycle while sitting in NEXT.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (start_round && first_ok) begin
          state_d = ST_ISSUE;
          ch_d    = first_ch;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (finish_ch) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (last_ch) begin
          state_d = ST_IDLE;
        end else begin
          ch_d    = nxt_ch;
          state_d = fault_q[nxt_ch] ? ST_NEXT : ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rpm_q     <= '0;
      duty_q    <= '0;
      valid_q   <= '0;
      fault_q   <= '0;
      overrun_q <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        shadow_q[n] <= '0;
        active_q[n] <= '0;
      end
    end else begin
      valid_q <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        shadow_q[n] <= shadow_nxt[n];
        if (start_round) begin
          active_q[n] <= shadow_nxt[n];
        end
      end
      if (state_q == ST_ISSUE) begin
        rpm_q <= i_rpm[ch_q*DATA_W +: DATA_W];
      end
      if (tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (finish_ch) begin
        valid_q[ch_q] <= 1'b1;
        if (pi.i_pi_done && !pi.i_pi_error) begin
          duty_q[ch_q*DUTY_W +: DUTY_W] <= pi.i_pi_dout;
        end else begin
          duty_q[ch_q*DUTY_W +: DUTY_W] <= '0;
          fault_q[ch_q]                 <= 1'b1;
        end
      end
    end
  end

  // Operands come from the round snapshot; RPM is live during ISSUE, then held.
  assign pi.o_pi_start = (state_q == ST_ISSUE);
  assign pi.o_pi_gain  = {active_q[ch_q].kp, active_q[ch_q].ki};
  assign pi.o_pi_sp    = active_q[ch_q].sp;
  assign pi.o_pi_rpm   = (state_q == ST_ISSUE) ? i_rpm[ch_q*DATA_W +: DATA_W] : rpm_q;

  assign o_duty       = duty_q;
  assign o_duty_valid = valid_q;
  assign o_fault      = fault_q;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_pi_scheduler.sv
// Self-checking bench for pi_scheduler: randomized rounds against a channel-level
// reference model, with a behavioural PI engine answering each start pulse.
module tb_pi_scheduler;

  localparam int NUM_CH  = 4;
  localparam int DELTA_T = 1;
  localparam int T_CLK   = 2000;
  localparam int CM      = DELTA_T * 1000000 / T_CLK;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic                 cfg_we;
  logic [1:0]           cfg_ch;
  logic [31:0]          cfg_gain;
  logic [31:0]          cfg_sp;
  logic [NUM_CH*32-1:0] rpm_bus;
  logic [NUM_CH*8-1:0]  duty;
  logic [NUM_CH-1:0]    duty_valid;
  logic [NUM_CH-1:0]    fault;
  logic                 busy;
  logic                 overrun;

  pi_scheduler_if pi_bus ();

  pi_scheduler #(
    .NUM_CH  (NUM_CH),
    .DELTA_T (DELTA_T),
    .T_CLK   (T_CLK)
  ) dut (
    .i_clk        (clk),
    .i_rstn       (rst_n),
    .i_en         (en),
    .i_cfg_we     (cfg_we),
    .i_cfg_ch     (cfg_ch),
    .i_cfg_gain   (cfg_gain),
    .i_cfg_sp     (cfg_sp),
    .i_rpm        (rpm_bus),
    .pi           (pi_bus),
    .o_duty       (duty),
    .o_duty_valid (duty_valid),
    .o_fault      (fault),
    .o_busy       (busy),
    .o_overrun    (overrun)
  );

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [31:0] m_gain [NUM_CH];
  logic [31:0] m_sp   [NUM_CH];
  logic [31:0] m_act_gain [NUM_CH];
  logic [31:0] m_act_sp   [NUM_CH];
  logic [31:0] m_rpm  [NUM_CH];
  logic [7:0]  m_duty [NUM_CH];
  bit          m_fault [NUM_CH];
  bit          m_overrun;

  logic [31:0] rec_gain [$];
  logic [31:0] rec_sp   [$];
  logic [31:0] rec_rpm  [$];
  int          rec_cyc  [$];
  logic [7:0]  resp_dout  [$];
  bit          resp_err   [$];
  int          resp_delay [$];
  int          vcnt [NUM_CH];

  bit         eng_pending = 0;
  int         eng_cnt = 0;
  logic [7:0] eng_dout = '0;
  bit         eng_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Behavioural engine: answers each start after the queued delay, unaware of resets.
  always @(negedge clk) begin
    pi_bus.i_pi_done  = 1'b0;
    pi_bus.i_pi_error = 1'b0;
    if (eng_pending) begin
      if (eng_cnt == 0) begin
        pi_bus.i_pi_done  = 1'b1;
        pi_bus.i_pi_dout  = eng_dout;
        pi_bus.i_pi_error = eng_err;
        eng_pending       = 0;
      end else begin
        eng_cnt--;
      end
    end
    if (pi_bus.o_pi_start === 1'b1) begin
      rec_gain.push_back(pi_bus.o_pi_gain);
      rec_sp.push_back(pi_bus.o_pi_sp);
      rec_rpm.push_back(pi_bus.o_pi_rpm);
      rec_cyc.push_back(cyc);
      if (resp_dout.size() > 0) begin
        eng_dout = resp_dout.pop_front();
        eng_err  = resp_err.pop_front();
        eng_cnt  = resp_delay.pop_front() - 1;
      end else begin
        eng_dout = '0;
        eng_err  = 0;
        eng_cnt  = 4;
      end
      eng_pending = 1;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (duty_valid[c] === 1'b1) vcnt[c]++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfgWrite(input int c, input logic [31:0] g, input logic [31:0] s);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(c);
    cfg_gain = g;
    cfg_sp   = s;
    m_gain[c] = g;
    m_sp[c]   = s;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic waitTick();
    int g = 0;
    while (((cyc % CM) != CM - 1) && (g < 2 * CM)) begin
      step(1);
      g++;
    end
    checkOutput("tick_reached", 64'(g < 2 * CM), 64'd1);
  endtask

  task automatic clearRecords();
    rec_gain.delete();
    rec_sp.delete();
    rec_rpm.delete();
    rec_cyc.delete();
    for (int c = 0; c < NUM_CH; c++) vcnt[c] = 0;
  endtask

  function automatic logic [31:0] expDuty();
    logic [31:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c*8 +: 8] = m_duty[c];
    return v;
  endfunction

  function automatic logic [3:0] expFault();
    logic [3:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = m_fault[c];
    return v;
  endfunction

  // One full round: queue engine answers, wait for the tick, then compare every issue.
  task automatic applyStimulus(input bit fixed_dout, input logic [3:0] err_mask, input int delay0,
                               input bit tick_write, input bit mid_sp500, input bit drop_en);
    int order [$];
    logic [7:0] rd [$];
    bit re [$];
    bit issued [NUM_CH];
    int g;
    int n;
    clearRecords();
    for (int c = 0; c < NUM_CH; c++) begin
      issued[c] = 0;
      if (!m_fault[c]) order.push_back(c);
    end
    for (int k = 0; k < order.size(); k++) begin
      rd.push_back(fixed_dout ? 8'(10 + order[k]) : 8'($urandom_range(0, 255)));
      re.push_back(err_mask[order[k]]);
      resp_dout.push_back(rd[k]);
      resp_err.push_back(re[k]);
      resp_delay.push_back((k == 0) ? delay0 : 5);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      m_rpm[c] = $urandom;
      rpm_bus[c*32 +: 32] = m_rpm[c];
    end
    waitTick();
    if (tick_write) cfgWrite(3, $urandom, $urandom);
    else step(1);
    for (int c = 0; c < NUM_CH; c++) begin
      m_act_gain[c] = m_gain[c];
      m_act_sp[c]   = m_sp[c];
    end
    if (mid_sp500 || drop_en) begin
      g = 0;
      while ((rec_sp.size() == 0) && (g < 20)) begin
        step(1);
        g++;
      end
      if (mid_sp500) cfgWrite(2, m_gain[2], 32'd500);
      if (drop_en) en = 1'b0;
    end
    g = 0;
    while ((busy !== 1'b0) && (g < delay0 + 200)) begin
      step(1);
      g++;
    end
    checkOutput("round_completes", 64'(g < delay0 + 200), 64'd1);
    if (delay0 >= CM) m_overrun = 1;

    checkOutput("issue_count", 64'(rec_sp.size()), 64'(order.size()));
    n = (rec_sp.size() < order.size()) ? rec_sp.size() : order.size();
    if (n > 0) checkOutput("start_latency", 64'(rec_cyc[0] % CM), 64'd0);
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("gain_ch%0d", order[k]), rec_gain[k], m_act_gain[order[k]]);
      checkOutput($sformatf("sp_ch%0d", order[k]),   rec_sp[k],   m_act_sp[order[k]]);
      checkOutput($sformatf("rpm_ch%0d", order[k]),  rec_rpm[k],  m_rpm[order[k]]);
    end
    for (int k = 0; k < order.size(); k++) begin
      issued[order[k]] = 1;
      if (re[k]) begin
        m_fault[order[k]] = 1;
        m_duty[order[k]]  = 8'd0;
      end else begin
        m_duty[order[k]] = rd[k];
      end
    end
    checkOutput("duty", duty, expDuty());
    checkOutput("fault", fault, expFault());
    checkOutput("overrun", overrun, m_overrun);
    checkOutput("busy_after_round", busy, 1'b0);
    for (int c = 0; c < NUM_CH; c++) begin
      checkOutput($sformatf("valid_pulses_ch%0d", c), 64'(vcnt[c]), 64'(issued[c]));
    end
  endtask

  task automatic checkIdleTick(input string tag);
    clearRecords();
    waitTick();
    step(5);
    checkOutput({tag, "_no_start"}, 64'(rec_sp.size()), 64'd0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_duty"}, duty, expDuty());
  endtask

  task automatic modelReset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_gain[c] = '0;
      m_sp[c] = '0;
      m_act_gain[c] = '0;
      m_act_sp[c] = '0;
      m_duty[c] = '0;
      m_fault[c] = 0;
    end
    m_overrun = 0;
  endtask

  initial begin
    rst_n    = 1'b0;
    en       = 1'b0;
    cfg_we   = 1'b0;
    cfg_ch   = '0;
    cfg_gain = '0;
    cfg_sp   = '0;
    rpm_bus  = '0;
    modelReset();
    step(3);
    checkOutput("reset_duty", duty, 32'd0);
    checkOutput("reset_valid", duty_valid, 4'd0);
    checkOutput("reset_fault", fault, 4'd0);
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_overrun", overrun, 1'b0);
    checkOutput("reset_start", pi_bus.o_pi_start, 1'b0);
    rst_n = 1'b1;

    $display("[TB] configuring channels");
    for (int c = 0; c < NUM_CH; c++) cfgWrite(c, $urandom, $urandom);
    en = 1'b1;

    $display("[TB] round with dout = 10 + ch");
    applyStimulus(1, 4'b0000, 5, 0, 0, 0);
    checkOutput("duty_10_to_13", duty, 32'h0D0C0B0A);

    $display("[TB] round with tick-cycle write and mid-round sp write");
    applyStimulus(0, 4'b0000, 5, 1, 1, 0);

    $display("[TB] round with engine error on ch1");
    applyStimulus(0, 4'b0010, 5, 0, 0, 0);
    checkOutput("ch2_sp_500", m_act_sp[2], 32'd500);
    checkOutput("fault_ch1", fault, 4'b0010);
    checkOutput("duty_ch1_zero", duty[15:8], 8'd0);

    $display("[TB] round skipping ch1, enable dropped mid-round");
    applyStimulus(0, 4'b0000, 5, 0, 0, 1);
    checkIdleTick("disabled_tick");
    en = 1'b1;

    $display("[TB] stalled engine across two tick periods");
    applyStimulus(0, 4'b0000, 2 * CM + 20, 0, 0, 0);
    checkOutput("overrun_set", overrun, 1'b1);

    $display("[TB] reset during WAIT with late done");
    clearRecords();
    resp_dout.push_back(8'h55);
    resp_err.push_back(0);
    resp_delay.push_back(40);
    waitTick();
    step(6);
    checkOutput("in_wait_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    en    = 1'b0;
    step(2);
    rst_n = 1'b1;
    modelReset();
    for (int c = 0; c < NUM_CH; c++) vcnt[c] = 0;
    step(60);
    checkOutput("rst_duty", duty, 32'd0);
    checkOutput("rst_valid_pulses", 64'(vcnt[0] + vcnt[1] + vcnt[2] + vcnt[3]), 64'd0);
    checkOutput("rst_fault", fault, 4'd0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_overrun", overrun, 1'b0);
    checkOutput("rst_start", pi_bus.o_pi_start, 1'b0);
    checkOutput("rst_gain", pi_bus.o_pi_gain, 32'd0);
    checkOutput("rst_sp", pi_bus.o_pi_sp, 32'd0);
    checkOutput("rst_rpm", pi_bus.o_pi_rpm, 32'd0);

    $display("[TB] all channels fault, next tick issues nothing");
    for (int c = 0; c < NUM_CH; c++) cfgWrite(c, $urandom, $urandom);
    en = 1'b1;
    applyStimulus(0, 4'b1111, 5, 0, 0, 0);
    checkIdleTick("all_faulted_tick");
    checkOutput("all_faulted", fault, 4'b1111);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pi_scheduler.md
PI_SCHEDULER -- requirements
Module: pi_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of motor channels sharing one PI engine (legal range 2..8); CHW = max(1, clog2(NUM_CH)).
REQ-002 The block SHALL have parameter DELTA_T, default 10, giving the control period in ms.
REQ-003 The block SHALL have parameter T_CLK, default 10, giving the clock period in ns.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port i_rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_en, input, 1 bit: enables starting new rounds.
REQ-007 The block SHALL have port i_cfg_we, input, 1 bit: configuration write strobe.
REQ-008 The block SHALL have port i_cfg_ch, input, CHW bits: channel targeted by a configuration write.
REQ-009 The block SHALL have port i_cfg_gain, input, 32 bits: {Kp[31:16], Ki[15:0]}, signed 5'10 each.
REQ-010 The block SHALL have port i_cfg_sp, input, 32 bits: signed setpoint RPM.
REQ-011 The block SHALL have port i_rpm, input, NUM_CH*32 bits: per-channel signed measured RPM; channel n occupies [32n+31:32n].
REQ-012 The block SHALL have port o_pi_start, output, 1 bit: one-cycle start pulse to the PI engine.
REQ-013 The block SHALL have port o_pi_gain, output, 32 bits: {Kp, Ki} of the channel in service.
REQ-014 The block SHALL have port o_pi_sp, output, 32 bits: setpoint of the channel in service.
REQ-015 The block SHALL have port o_pi_rpm, output, 32 bits: RPM of the channel in service, sampled at issue.
REQ-016 The block SHALL have port i_pi_done, input, 1 bit: engine result valid.
REQ-017 The block SHALL have port i_pi_dout, input, 8 bits: engine duty result (0-255).
REQ-018 The block SHALL have port i_pi_error, input, 1 bit: engine overflow flag, qualified by i_pi_done.
REQ-019 The block SHALL have port o_duty, output, NUM_CH*8 bits: per-channel PWM duty; channel n occupies [8n+7:8n].
REQ-020 The block SHALL have port o_duty_valid, output, NUM_CH bits: per-channel one-cycle update pulse.
REQ-021 The block SHALL have port o_fault, output, NUM_CH bits: per-channel sticky fault.
REQ-022 The block SHALL have port o_busy, output, 1 bit: asserted whenever the FSM is not in IDLE.
REQ-023 The block SHALL have port o_overrun, output, 1 bit: sticky flag for a tick arriving while busy.

Function
REQ-024 The block SHALL generate a tick once every C_M = DELTA_T*1_000_000/T_CLK cycles, with the counter running from 0 to C_M-1 and wrapping.
REQ-025 A configuration write SHALL update only the shadow registers (gain, sp) of channel i_cfg_ch; a write with i_cfg_ch >= NUM_CH SHALL be ignored.
REQ-026 On a tick with i_en=1 in IDLE, the block SHALL copy all shadow registers to active registers, with any write in that same cycle included, and then enter ISSUE for the lowest-numbered non-faulted channel.
REQ-027 The FSM SHALL have states IDLE, ISSUE, WAIT and NEXT; ISSUE SHALL last exactly one cycle with o_pi_start=1 and o_pi_* driven from the active registers, then go to WAIT.
REQ-028 o_pi_* SHALL hold their values from ISSUE until the FSM leaves WAIT.
REQ-029 In WAIT, i_pi_done=1 SHALL latch i_pi_dout into o_duty[ch], pulse o_duty_valid[ch] in the next cycle and go to NEXT; i_pi_done SHALL be ignored in all other states.
REQ-030 i_pi_done=1 together with i_pi_error=1 SHALL set o_fault[ch], force o_duty[ch] to 0 and pulse o_duty_valid[ch].
REQ-031 NEXT SHALL advance to the next non-faulted channel, skipping faulted channels at one cycle each, and SHALL return to IDLE after channel NUM_CH-1.
REQ-032 If all channels are faulted, a tick SHALL be consumed with no o_pi_start.
REQ-033 A tick while o_busy=1 SHALL set o_overrun and be dropped; the round in progress SHALL continue unaffected.
REQ-034 Deasserting i_en mid-round SHALL let the current round finish and block only new rounds.
REQ-035 Latency from a tick to the first o_pi_start SHALL be exactly 1 cycle.

Reset
REQ-036 Asserting i_rstn low SHALL asynchronously force: state IDLE, tick counter 0, all shadow and active registers 0, and o_pi_start, o_duty, o_duty_valid, o_fault, o_busy, o_overrun all 0; this SHALL apply mid-round as well, and any late i_pi_done after reset SHALL be ignored.

Configuration
REQ-037 With PI_SCHED_TIMEOUT_EN defined, a WAIT lasting 256 cycles without i_pi_done SHALL set o_fault[ch], force o_duty[ch] to 0 and go to NEXT; if i_pi_done arrives in the expiry cycle, done SHALL win.
REQ-038 Without PI_SCHED_TIMEOUT_EN, WAIT SHALL be unbounded and no timeout counter SHALL exist.

Structure
REQ-039 Package pi_sched_pkg SHALL hold the FSM state enum, the chan_cfg_t struct {kp, ki, sp}, and the localparams PI_TIMEOUT=256 and the gain/duty widths.
REQ-040 The tick counter SHALL be the sub-module pi_tick_gen (parameters DELTA_T and T_CLK, output o_tick).

Verification
REQ-041 NUM_CH=4 with engine model done after 5 cycles returning dout=10+ch -> per tick, four o_pi_start pulses in order 0,1,2,3; o_duty = {13,12,11,10}; o_busy drops after the last.
REQ-042 Write ch2 sp=500 mid-round -> the current round issues the old sp; the next round issues o_pi_sp=500 to ch2.
REQ-043 Engine returns error for ch1 -> o_fault=4'b0010, o_duty[1]=0; later rounds issue only channels 0, 2 and 3.
REQ-044 Engine stalls past two tick periods -> o_overrun=1 and the stalled round completes; with PI_SCHED_TIMEOUT_EN, timeout at 256 cycles sets o_fault[ch] and the round continues.
REQ-045 Assert i_rstn during WAIT, then release and send a late i_pi_done -> all outputs 0 and the done is ignored.
